// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, held-request imem handshake, one-entry skid buffer, redirect flush sequence.
// Optional FETCH_ALIGN_CHK_EN: odd redirect targets raise a sticky err and halt fetching.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        valid,
    output logic        flush,
    output logic        flush_again,
    output logic        flush_final,
    output logic        err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALTED} state_t;

    localparam logic [15:0] NOP = 16'h0800;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] saved_pc_q, saved_pc_d;
    logic        saved_bad_q, saved_bad_d;
    logic        skid_full_q, skid_full_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pcinc_q, skid_pcinc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_inc_q, pc_inc_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        flush_again_q, flush_again_d;
    logic        flush_final_q, flush_final_d;

    logic        misaligned;
    logic [15:0] target;
    logic        capture;
    logic        cap_halt;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;

    assign misaligned = redirect_pc[0];
    assign target     = redirect_pc;

    always_comb begin
        err_d = err_q | (redirect & redirect_pc[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign misaligned = 1'b0;
    assign target     = redirect_pc & 16'hFFFE;
    assign err        = 1'b0;
`endif

    // A request is never raised in a redirect cycle, so no half-started request is abandoned.
    assign imem_rd = !rst && ((state_q == S_WAIT) || (state_q == S_DRAIN) ||
                     ((state_q == S_REQ) && !stall && !skid_full_q && !redirect));
    assign imem_addr = pc_q;

    assign capture  = imem_rd && imem_done && !redirect &&
                      ((state_q == S_REQ) || (state_q == S_WAIT));
    assign cap_halt = capture && (imem_data[15:11] == 5'b00000);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        saved_pc_d    = saved_pc_q;
        saved_bad_d   = saved_bad_q;
        skid_full_d   = skid_full_q;
        skid_instr_d  = skid_instr_q;
        skid_pcinc_d  = skid_pcinc_q;
        instr_d       = instr_q;
        pc_inc_d      = pc_inc_q;
        valid_d       = valid_q;
        flush_d       = redirect;
        flush_again_d = flush_q && !redirect;
        flush_final_d = flush_again_q && !redirect;

        if (redirect) begin
            valid_d     = 1'b0;
            instr_d     = NOP;
            skid_full_d = 1'b0;
            // An outstanding request must still be drained unless it completes right now.
            if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_done) begin
                saved_pc_d  = target;
                saved_bad_d = misaligned;
                state_d     = S_DRAIN;
            end else begin
                pc_d    = target;
                state_d = misaligned ? S_HALTED : S_REQ;
            end
        end else begin
            if (!stall) begin
                if (skid_full_q) begin
                    instr_d     = skid_instr_q;
                    pc_inc_d    = skid_pcinc_q;
                    valid_d     = 1'b1;
                    skid_full_d = 1'b0;
                end else if (capture) begin
                    instr_d  = imem_data;
                    pc_inc_d = pc_q + 16'd2;
                    valid_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (capture) begin
                skid_full_d  = 1'b1;
                skid_instr_d = imem_data;
                skid_pcinc_d = pc_q + 16'd2;
            end

            case (state_q)
                S_REQ: begin
                    if (imem_rd) begin
                        if (imem_done) begin
                            pc_d    = pc_q + 16'd2;
                            state_d = cap_halt ? S_HALTED : S_REQ;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_done) begin
                        pc_d    = pc_q + 16'd2;
                        state_d = cap_halt ? S_HALTED : S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_done) begin
                        pc_d    = saved_pc_q;
                        state_d = saved_bad_q ? S_HALTED : S_REQ;
                    end
                end
                default: begin
                    state_d = S_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= 16'h0000;
            saved_pc_q    <= 16'h0000;
            saved_bad_q   <= 1'b0;
            skid_full_q   <= 1'b0;
            skid_instr_q  <= NOP;
            skid_pcinc_q  <= 16'h0000;
            instr_q       <= NOP;
            pc_inc_q      <= 16'h0000;
            valid_q       <= 1'b0;
            flush_q       <= 1'b0;
            flush_again_q <= 1'b0;
            flush_final_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            saved_pc_q    <= saved_pc_d;
            saved_bad_q   <= saved_bad_d;
            skid_full_q   <= skid_full_d;
            skid_instr_q  <= skid_instr_d;
            skid_pcinc_q  <= skid_pcinc_d;
            instr_q       <= instr_d;
            pc_inc_q      <= pc_inc_d;
            valid_q       <= valid_d;
            flush_q       <= flush_d;
            flush_again_q <= flush_again_d;
            flush_final_q <= flush_final_d;
        end
    end

    assign instr       = instr_q;
    assign pc_inc      = pc_inc_q;
    assign valid       = valid_q;
    assign flush       = flush_q;
    assign flush_again = flush_again_q;
    assign flush_final = flush_final_q;

endmodule
